// File: rtl/gol_pkg.sv
// Shared definitions for the Game of Life host-side run controller.
//   GOL_ADDR_W / GOL_BUF_A / GOL_BUF_B : default on-chip memory width and the
//                                        two board buffer bases, shared with
//                                        the top level and the engine wrapper.
//   seq_state_e                        : run controller FSM states.
package gol_pkg;

    localparam int GOL_ADDR_W = 12;
    localparam logic [GOL_ADDR_W-1:0] GOL_BUF_A = 12'h000;
    localparam logic [GOL_ADDR_W-1:0] GOL_BUF_B = 12'h800;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENG_RST,
        S_INIT,
        S_START,
        S_RELEASE,
        S_SWAP,
        S_FLUSH
    } seq_state_e;

endpackage

// File: rtl/gol_watchdog.sv
// Per-generation watchdog: a down-counter reloaded by clear and decremented
// while enabled. expired is high once LIMIT enabled cycles have elapsed since
// the last clear, so a phase guarded by it lasts at most LIMIT cycles.
//   clock, reset : clock and asynchronous active-high reset
//   clear        : reload the counter (wins over enable)
//   enable       : count this cycle
//   expired      : limit reached
module gol_watchdog #(
    parameter int            W     = 24,
    parameter logic [W-1:0]  LIMIT = '1
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [W-1:0] remaining;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            remaining <= LIMIT - W'(1);
        end else if (clear) begin
            remaining <= LIMIT - W'(1);
        end else if (enable && remaining != '0) begin
            remaining <= remaining - W'(1);
        end
    end

    assign expired = (remaining == '0);

endmodule

// File: rtl/gol_host_sequencer.sv
// Hardware run controller for the Game of Life engine. Runs a requested number
// of generations back-to-back, ping-ponging the engine between two board
// buffers, and reports completion, timeout and the buffer holding the newest
// valid board.
//   clock, reset            : clock, asynchronous active-high reset
//   cmd_run/cmd_generations : start request (IDLE only) and generation count
//   cmd_abort               : level abort of the current run
//   eng_*                   : engine reset/initialize/start and buffer bases,
//                             eng_completed is the engine's done level
//   busy/done/error         : run in progress, success pulse, sticky timeout
//   gen_count/final_address : progress and latest valid board buffer
// TIMEOUT_LIMIT defaults to 2^TIMEOUT_W-1 cycles per generation; it can be
// lowered for bring-up and simulation.
module gol_host_sequencer
    import gol_pkg::*;
#(
    parameter int                    ADDR_W        = GOL_ADDR_W,
    parameter logic [ADDR_W-1:0]     BUF_A         = ADDR_W'(GOL_BUF_A),
    parameter logic [ADDR_W-1:0]     BUF_B         = ADDR_W'(GOL_BUF_B),
    parameter int                    GEN_W         = 16,
    parameter int                    TIMEOUT_W     = 24,
    parameter logic [TIMEOUT_W-1:0]  TIMEOUT_LIMIT = '1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_run,
    input  logic [GEN_W-1:0]  cmd_generations,
    input  logic              cmd_abort,
    output logic              eng_reset,
    output logic              eng_initialize,
    output logic              eng_start,
    output logic [ADDR_W-1:0] eng_starting_address,
    output logic [ADDR_W-1:0] eng_result_address,
    input  logic              eng_completed,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [GEN_W-1:0]  gen_count,
    output logic [ADDR_W-1:0] final_address
);

    seq_state_e        state, state_d;
    logic              hold, hold_d;            // second cycle of ENG_RST / FLUSH
    logic              abort_pend, abort_pend_d; // abort that arrived with cmd_run
    logic [GEN_W-1:0]  target, target_d;
    logic [GEN_W-1:0]  gen_d;
    logic              error_d, done_d;
    logic [ADDR_W-1:0] final_d, src_d, dst_d;
    logic              abort_now;
    logic              wd_clear, wd_enable, wd_expired;

    assign abort_now = cmd_abort | abort_pend;
    assign wd_clear  = (state_d == S_START) && (state != S_START);
    assign wd_enable = (state == S_START) || (state == S_RELEASE);

    gol_watchdog #(
        .W     (TIMEOUT_W),
        .LIMIT (TIMEOUT_LIMIT)
    ) u_watchdog (
        .clock   (clock),
        .reset   (reset),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    always_comb begin
        state_d      = state;
        hold_d       = 1'b0;
        abort_pend_d = 1'b0;
        target_d     = target;
        gen_d        = gen_count;
        error_d      = error;
        done_d       = 1'b0;
        final_d      = final_address;
        src_d        = eng_starting_address;
        dst_d        = eng_result_address;

        if (state != S_IDLE && state != S_FLUSH && abort_now) begin
            state_d = S_FLUSH;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_run) begin
                        target_d = cmd_generations;
                        gen_d    = '0;
                        error_d  = 1'b0;
                        src_d    = BUF_A;
                        dst_d    = BUF_B;
                        final_d  = BUF_A;
                        if (cmd_generations == '0) begin
                            done_d = 1'b1;
                        end else begin
                            state_d      = S_ENG_RST;
                            abort_pend_d = cmd_abort;
                        end
                    end
                end
                S_ENG_RST: begin
                    if (hold) state_d = S_INIT;
                    else      hold_d  = 1'b1;
                end
                S_INIT: state_d = S_START;
                S_START: begin
                    if (eng_completed) begin
                        state_d = S_RELEASE;
                        if (gen_count != target) gen_d = gen_count + GEN_W'(1);
                        // Result buffer is valid as soon as the engine reports done.
                        final_d = eng_result_address;
                    end else if (wd_expired) begin
                        error_d = 1'b1;
                        state_d = S_FLUSH;
                    end
                end
                S_RELEASE: begin
                    if (!eng_completed) begin
                        if (gen_count == target) begin
                            done_d  = 1'b1;
                            final_d = eng_result_address;
                            state_d = S_IDLE;
                        end else begin
                            // Swap on entry so the new bases are visible during SWAP.
                            src_d   = eng_result_address;
                            dst_d   = eng_starting_address;
                            state_d = S_SWAP;
                        end
                    end else if (wd_expired) begin
                        error_d = 1'b1;
                        state_d = S_FLUSH;
                    end
                end
                S_SWAP: state_d = S_START;
                S_FLUSH: begin
                    if (hold) state_d = S_IDLE;
                    else      hold_d  = 1'b1;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state and registered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state                <= S_IDLE;
            hold                 <= 1'b0;
            abort_pend           <= 1'b0;
            target               <= '0;
            gen_count            <= '0;
            error                <= 1'b0;
            done                 <= 1'b0;
            final_address        <= BUF_A;
            eng_starting_address <= BUF_A;
            eng_result_address   <= BUF_B;
            busy                 <= 1'b0;
            eng_reset            <= 1'b1;
            eng_initialize       <= 1'b0;
            eng_start            <= 1'b0;
        end else begin
            state                <= state_d;
            hold                 <= hold_d;
            abort_pend           <= abort_pend_d;
            target               <= target_d;
            gen_count            <= gen_d;
            error                <= error_d;
            done                 <= done_d;
            final_address        <= final_d;
            eng_starting_address <= src_d;
            eng_result_address   <= dst_d;
            busy                 <= (state_d != S_IDLE);
            eng_reset            <= (state_d == S_ENG_RST) || (state_d == S_FLUSH);
            eng_initialize       <= (state_d == S_INIT);
            eng_start            <= (state_d == S_START);
        end
    end

endmodule

// File: tb/tb_gol_host_sequencer.sv
// Bench for gol_host_sequencer: engine model with configurable completion
// latency, address/done monitor, directed and randomized runs.
module tb_gol_host_sequencer;

    localparam logic [11:0] A = 12'h000;
    localparam logic [11:0] B = 12'h800;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_run = 1'b0;
    logic [15:0] cmd_generations = '0;
    logic        cmd_abort = 1'b0;
    logic        eng_reset, eng_initialize, eng_start;
    logic [11:0] eng_starting_address, eng_result_address;
    logic        eng_completed;
    logic        busy, done, error;
    logic [15:0] gen_count;
    logic [11:0] final_address;

    gol_host_sequencer #(
        .TIMEOUT_W     (24),
        .TIMEOUT_LIMIT (24'd100)
    ) dut (
        .clock                (clock),
        .reset                (reset),
        .cmd_run              (cmd_run),
        .cmd_generations      (cmd_generations),
        .cmd_abort            (cmd_abort),
        .eng_reset            (eng_reset),
        .eng_initialize       (eng_initialize),
        .eng_start            (eng_start),
        .eng_starting_address (eng_starting_address),
        .eng_result_address   (eng_result_address),
        .eng_completed        (eng_completed),
        .busy                 (busy),
        .done                 (done),
        .error                (error),
        .gen_count            (gen_count),
        .final_address        (final_address)
    );

    always #5 clock = ~clock;

    // Engine model: completed rises lat_cfg cycles after start, falls
    // fall_cfg cycles after start drops; eng_hang keeps it from completing.
    int lat_cfg = 10;
    int fall_cfg = 1;
    bit eng_hang = 1'b0;
    int ecnt;

    always @(posedge clock or posedge reset) begin
        if (reset || eng_reset) begin
            eng_completed <= 1'b0;
            ecnt <= 0;
        end else if (eng_start && !eng_completed) begin
            if (!eng_hang) begin
                if (ecnt + 1 >= lat_cfg) begin eng_completed <= 1'b1; ecnt <= 0; end
                else ecnt <= ecnt + 1;
            end
        end else if (!eng_start && eng_completed) begin
            if (ecnt + 1 >= fall_cfg) begin eng_completed <= 1'b0; ecnt <= 0; end
            else ecnt <= ecnt + 1;
        end
    end

    // Monitor: addresses at each start rise, address changes while started,
    // done pulses and done pulses that coincide with busy falling.
    logic [11:0] src_q[$];
    logic [11:0] dst_q[$];
    logic        start_prev = 1'b0, busy_prev = 1'b0;
    logic [11:0] src_prev = '0, dst_prev = '0;
    int          done_cnt = 0, done_fall_cnt = 0, addr_chg_cnt = 0;

    always @(negedge clock) begin
        start_prev <= eng_start;
        busy_prev  <= busy;
        src_prev   <= eng_starting_address;
        dst_prev   <= eng_result_address;
        if (eng_start && !start_prev) begin
            src_q.push_back(eng_starting_address);
            dst_q.push_back(eng_result_address);
        end
        if (eng_start && start_prev &&
            (eng_starting_address != src_prev || eng_result_address != dst_prev))
            addr_chg_cnt <= addr_chg_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (done && busy_prev && !busy) done_fall_cnt <= done_fall_cnt + 1;
    end

    int n_assert = 0;
    int n_fail = 0;
    int d0, f0, r0, a0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        #1;
        d0 = done_cnt; f0 = done_fall_cnt; r0 = src_q.size(); a0 = addr_chg_cnt;
    endtask

    task automatic kick(input int n);
        @(negedge clock); cmd_run = 1'b1; cmd_generations = 16'(n);
        @(negedge clock); cmd_run = 1'b0;
        chk("acc_busy", 32'(busy), 1);
        chk("eng_rst_c1", 32'(eng_reset), 1);
        @(negedge clock);
        chk("eng_rst_c2", 32'(eng_reset), 1);
        chk("init_early", 32'(eng_initialize), 0);
        @(negedge clock);
        chk("init", 32'(eng_initialize), 1);
        chk("eng_rst_off", 32'(eng_reset), 0);
        @(negedge clock);
        chk("start", 32'(eng_start), 1);
        chk("src0", 32'(eng_starting_address), 32'(A));
        chk("dst0", 32'(eng_result_address), 32'(B));
    endtask

    task automatic wait_idle(input int bound, input string tag);
        int cyc = 0;
        while (busy && cyc < bound) begin @(negedge clock); cyc++; end
        chk(tag, 32'(cyc < bound), 1);
        #1;
    endtask

    // Reference: generation i reads buffer A when i is even, B when odd; the
    // final board lands in the destination of the last generation.
    task automatic check_run(input int n);
        chk("gen_count", 32'(gen_count), 32'(n));
        chk("final_addr", 32'(final_address), 32'((n % 2 == 1) ? B : A));
        chk("error_clr", 32'(error), 0);
        chk("done_pulses", 32'(done_cnt - d0), 1);
        chk("done_w_busy_fall", 32'(done_fall_cnt - f0), 1);
        chk("start_rises", 32'(src_q.size() - r0), 32'(n));
        chk("addr_stable", 32'(addr_chg_cnt - a0), 0);
        for (int i = 0; i < n && r0 + i < src_q.size(); i++) begin
            chk("gen_src", 32'(src_q[r0+i]), 32'((i % 2 == 0) ? A : B));
            chk("gen_dst", 32'(dst_q[r0+i]), 32'((i % 2 == 0) ? B : A));
        end
    endtask

    task automatic run_gens(input int n, input int lat, input int fall);
        lat_cfg = lat; fall_cfg = fall;
        snap();
        kick(n);
        wait_idle(n * (lat + fall + 10) + 50, "run_finish");
        check_run(n);
    endtask

    initial begin
        // Reset values
        @(negedge clock); @(negedge clock);
        chk("rst_eng_reset", 32'(eng_reset), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_error", 32'(error), 0);
        chk("rst_start", 32'(eng_start), 0);
        chk("rst_init", 32'(eng_initialize), 0);
        chk("rst_src", 32'(eng_starting_address), 32'(A));
        chk("rst_dst", 32'(eng_result_address), 32'(B));
        chk("rst_gen", 32'(gen_count), 0);
        chk("rst_final", 32'(final_address), 32'(A));
        reset = 1'b0;
        @(negedge clock);
        chk("rst_release_eng_reset", 32'(eng_reset), 0);
        chk("rst_release_busy", 32'(busy), 0);

        // Zero generations: immediate done, no engine activity
        snap();
        @(negedge clock); cmd_run = 1'b1; cmd_generations = 16'd0;
        @(negedge clock); cmd_run = 1'b0;
        chk("g0_done", 32'(done), 1);
        chk("g0_busy", 32'(busy), 0);
        chk("g0_final", 32'(final_address), 32'(A));
        @(negedge clock);
        chk("g0_done_once", 32'(done), 0);
        chk("g0_eng_reset", 32'(eng_reset), 0);
        #1;
        chk("g0_done_cnt", 32'(done_cnt - d0), 1);
        chk("g0_no_start", 32'(src_q.size() - r0), 0);

        // Three generations, directed latencies
        run_gens(3, 10, 1);

        // Randomized runs
        for (int k = 0; k < 4; k++)
            run_gens(int'($urandom_range(1, 6)), int'($urandom_range(1, 20)),
                     int'($urandom_range(1, 4)));

        // cmd_run during a run is ignored
        lat_cfg = 10; fall_cfg = 1;
        snap();
        kick(2);
        @(negedge clock); @(negedge clock);
        cmd_run = 1'b1; cmd_generations = 16'd7;
        @(negedge clock); cmd_run = 1'b0;
        wait_idle(200, "ign_finish");
        check_run(2);

        // Watchdog timeout: engine never completes, limit 100 cycles
        eng_hang = 1'b1;
        snap();
        kick(2);
        for (int j = 1; j < 100; j++) @(negedge clock);
        chk("wd_still_start", 32'(eng_start), 1);
        chk("wd_no_err_yet", 32'(error), 0);
        @(negedge clock);
        chk("wd_error", 32'(error), 1);
        chk("wd_flush_rst1", 32'(eng_reset), 1);
        chk("wd_flush_nostart", 32'(eng_start), 0);
        chk("wd_flush_busy", 32'(busy), 1);
        @(negedge clock);
        chk("wd_flush_rst2", 32'(eng_reset), 1);
        @(negedge clock);
        chk("wd_idle_rst", 32'(eng_reset), 0);
        chk("wd_idle_busy", 32'(busy), 0);
        chk("wd_err_sticky", 32'(error), 1);
        #1;
        chk("wd_no_done", 32'(done_cnt - d0), 0);
        chk("wd_final", 32'(final_address), 32'(A));
        chk("wd_gen", 32'(gen_count), 0);
        eng_hang = 1'b0;

        // A run after the timeout clears error
        run_gens(int'($urandom_range(1, 5)), int'($urandom_range(2, 15)), 1);

        // Abort during the second of four generations
        lat_cfg = 10; fall_cfg = 1;
        snap();
        kick(4);
        begin
            int cyc = 0;
            while (src_q.size() - r0 < 2 && cyc < 200) begin @(negedge clock); cyc++; end
            chk("ab_reach_gen2", 32'(cyc < 200), 1);
        end
        @(negedge clock); @(negedge clock); @(negedge clock);
        cmd_abort = 1'b1;
        @(negedge clock); cmd_abort = 1'b0;
        chk("ab_flush_rst", 32'(eng_reset), 1);
        chk("ab_flush_nostart", 32'(eng_start), 0);
        wait_idle(20, "ab_finish");
        chk("ab_error", 32'(error), 0);
        chk("ab_no_done", 32'(done_cnt - d0), 0);
        chk("ab_gen", 32'(gen_count), 1);
        chk("ab_final", 32'(final_address), 32'(B));

        // cmd_run and cmd_abort together in IDLE
        snap();
        @(negedge clock); cmd_run = 1'b1; cmd_abort = 1'b1; cmd_generations = 16'd3;
        @(negedge clock); cmd_run = 1'b0; cmd_abort = 1'b0;
        chk("ra_busy", 32'(busy), 1);
        chk("ra_rst1", 32'(eng_reset), 1);
        @(negedge clock);
        chk("ra_flush_busy", 32'(busy), 1);
        chk("ra_flush_rst", 32'(eng_reset), 1);
        @(negedge clock);
        chk("ra_no_init", 32'(eng_initialize), 0);
        chk("ra_flush_rst2", 32'(eng_reset), 1);
        @(negedge clock);
        chk("ra_idle", 32'(busy), 0);
        chk("ra_idle_rst", 32'(eng_reset), 0);
        #1;
        chk("ra_no_start", 32'(src_q.size() - r0), 0);
        chk("ra_no_done", 32'(done_cnt - d0), 0);
        chk("ra_no_error", 32'(error), 0);

        // Reset mid-run
        snap();
        kick(3);
        @(negedge clock); @(negedge clock);
        reset = 1'b1;
        #1;
        chk("mr_busy", 32'(busy), 0);
        chk("mr_eng_reset", 32'(eng_reset), 1);
        chk("mr_start", 32'(eng_start), 0);
        chk("mr_gen", 32'(gen_count), 0);
        chk("mr_final", 32'(final_address), 32'(A));
        @(negedge clock); reset = 1'b0;
        @(negedge clock);
        chk("mr_eng_reset_rel", 32'(eng_reset), 0);
        #1;
        chk("mr_no_done", 32'(done_cnt - d0), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/gol_host_sequencer.md
# gol_host_sequencer

Hardware-side run controller for the Game of Life engine. It drives the engine's reset, initialize and start controls and its starting/result buffer addresses, and observes the engine's `completed` flag. It runs a requested number of generations back-to-back in on-chip memory, ping-ponging between two board buffers, so multi-generation runs need no HPS round trip per generation. It sits beside the engine in the top level and takes the place of the PIO-driven control path.

## Interface
Parameters:
- `ADDR_W`, 12: on-chip memory address width (byte addresses).
- `BUF_A`, 12'h000: base address of board buffer A (generation-0 seed).
- `BUF_B`, 12'h800: base address of board buffer B.
- `GEN_W`, 16: generation counter width.
- `TIMEOUT_W`, 24: watchdog width; limit is 2^TIMEOUT_W−1 cycles per generation.

Ports:
- `clock` in 1: single clock for the whole block.
- `reset` in 1: asynchronous, active-high.
- `cmd_run` in 1: one-cycle start request; honoured only in IDLE.
- `cmd_generations` in GEN_W: number of generations; sampled with `cmd_run`.
- `cmd_abort` in 1: level; abort the current run.
- `eng_reset` out 1: engine reset, active-high.
- `eng_initialize` out 1: engine initialize strobe.
- `eng_start` out 1: engine start level.
- `eng_starting_address` out ADDR_W: source buffer base.
- `eng_result_address` out ADDR_W: destination buffer base.
- `eng_completed` in 1: engine done level, same clock domain.
- `busy` out 1: run in progress.
- `done` out 1: one-cycle pulse when the run finishes successfully.
- `error` out 1: sticky watchdog-timeout flag; cleared by the next accepted `cmd_run`.
- `gen_count` out GEN_W: generations completed in the current or last run.
- `final_address` out ADDR_W: buffer holding the latest valid board.

## Operation
States: IDLE, ENG_RST, INIT, START, RELEASE, SWAP, FLUSH.
- IDLE:
  - `cmd_run`=1 latches `target`=`cmd_generations`, clears `gen_count` and `error`, and loads src=BUF_A, dst=BUF_B.
  - `target`==0: assert `done` next cycle, set `final_address`=BUF_A, stay IDLE, no engine activity.
  - `target`≠0: go to ENG_RST.
- ENG_RST: `eng_reset`=1 for exactly 2 cycles, then INIT.
- INIT: `eng_initialize`=1 for exactly 1 cycle, then START.
- START:
  - `eng_start`=1.
  - Wait for `eng_completed`=1, then `gen_count`++ and go to RELEASE.
- RELEASE:
  - `eng_start`=0.
  - Wait for `eng_completed`=0.
  - If `gen_count`==`target`: `final_address`=dst, pulse `done`, go IDLE.
  - Otherwise: go to SWAP.
- SWAP: 1 cycle; exchange src and dst, then START. The engine is not re-initialized between generations.
- Watchdog:
  - Counter clears on entry to START.
  - Counts in START and RELEASE.
  - At the limit: set `error`, go to FLUSH.
- FLUSH:
  - `eng_reset`=1 and `eng_start`=0 for 2 cycles, then IDLE.
  - No `done`; `final_address` = last dst fully completed, or BUF_A if none.
- `cmd_abort`=1 in any non-IDLE state: go to FLUSH next cycle, with no `error` and no `done`. In IDLE, `cmd_abort` is ignored.
- `cmd_abort` and `cmd_run` asserted in the same cycle in IDLE: the run is accepted, then aborted in the following cycle.
- `cmd_run` while not IDLE: ignored.
- `gen_count` saturates at `target`; there is no wrap because `target` ≤ 2^GEN_W−1.

## Timing
- All outputs are registered.
- Reset values: `eng_reset`=1, all other control outputs 0, addresses = BUF_A/BUF_B, `gen_count`=0, `final_address`=BUF_A, state=IDLE.
  - `eng_reset` drops to 0 on the first clock edge after `reset` deasserts.
- `cmd_run` at edge n: `busy`=1 and `eng_reset`=1 at n+1 and n+2; `eng_initialize`=1 at n+3; `eng_start`=1 from n+4.
- `eng_starting_address` and `eng_result_address` are stable from INIT through RELEASE. They change only in SWAP, one cycle before `eng_start` rises again.
- `eng_completed` seen high at edge k: `eng_start`=0 at k+1, and `gen_count` updates at k+1.
- Per-generation overhead: 1 cycle (RELEASE exit) + 1 cycle (SWAP), plus the engine's `completed` fall time.
- `done` is high for exactly 1 cycle, in the same cycle that `busy` falls.
- `reset` mid-run: immediate return to reset values; no `done`.

## Structure
- Shared package `gol_pkg`:
  - state enum;
  - `ADDR_W`, `BUF_A`, `BUF_B` defaults, shared with the top level and the engine wrapper instance.
- Sub-module `gol_watchdog`: loadable counter with `clear`/`enable`/`expired`.
- Everything else is one FSM plus its datapath registers.

## Test plan
- Reset with `eng_completed`=0 → `eng_reset`=1 during reset, 0 one cycle after reset release; all other outputs at their reset values.
- `cmd_run` with generations=0 → `done` pulse next cycle; `final_address`=0x000; `eng_start` never rises.
- generations=3, engine model completes 10 cycles after start and drops `completed` 1 cycle after start falls → source/result addresses A→B, B→A, A→B; `gen_count`=3; `final_address`=0x800; single `done` pulse.
- generations=2, `completed` never asserts, watchdog reduced to 100 cycles → `error`=1 after 100 cycles in START; `eng_reset` high for 2 cycles; `done` never pulses; `final_address`=0x000.
- `cmd_abort` during the second generation of 4 → FLUSH, `error`=0, no `done`, `gen_count`=1, `final_address`=0x800.
- `cmd_run` during a run is ignored; `cmd_run` and `cmd_abort` in the same IDLE cycle → run accepted (`busy`=1), then FLUSH on the next edge.
